array_drain: RTL
================

ARRAY_DRAIN -- requirements
Module: array_drain

Interface
REQ-001 Parameter WIDTH, default 14, number of array columns.
REQ-002 Parameter OWIDTH, default 24, signed result width per column.
REQ-003 Parameter DEPTH, default 4, result-vector buffer entries, power of two, at least 2.
REQ-004 clk  input  1  single clock, all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 ofm  input  signed OWIDTH x WIDTH (unpacked [WIDTH-1:0])  column results from the array.
REQ-007 vld_o  input  1  column 0 result valid this cycle; column w valid exactly w cycles later.
REQ-008 in_rdy  output  1  a slot is reservable, so a vld_o pulse this cycle will be accepted.
REQ-009 ovf  output  1  sticky flag: a vld_o pulse was dropped.
REQ-010 m_data  output  signed OWIDTH  serialized result, one column per beat.
REQ-011 m_vld  output  1  m_data valid.
REQ-012 m_rdy  input  1  downstream accepts the beat.
REQ-013 m_last  output  1  beat carries column WIDTH-1 of the current vector.

Function
REQ-014 Acceptance: vld_o with in_rdy=1 reserves slot wr_ptr and increments wr_ptr modulo DEPTH; the slot index travels in a WIDTH-stage skew pipeline beside the valid bit.
REQ-015 Capture: column w of the vector accepted in cycle t is written into its reserved slot at the edge ending cycle t+w; vld_o may be asserted on consecutive cycles, giving up to WIDTH vectors in flight.
REQ-016 Commit: the vector is committed at the edge ending cycle t+WIDTH-1; the earliest m_vld for it is cycle t+WIDTH.
REQ-017 in_rdy = (committed + in-flight entries) < DEPTH, combinational from registered counts only.
REQ-018 Overflow: vld_o with in_rdy=0 is dropped (no slot, no capture) and sets ovf; ovf clears only on reset.
REQ-019 Output: m_vld=1 whenever at least one committed entry exists.
REQ-019a m_data = head entry[col]; col runs 0..WIDTH-1.
REQ-019b Each m_vld&&m_rdy beat advances col; m_last=1 when col=WIDTH-1.
REQ-020 Pop: the m_last handshake frees the head slot, resets col to 0, and advances rd_ptr modulo DEPTH; the next vector's column 0 may follow in the next cycle.
REQ-021 Stall: while m_vld=1 and m_rdy=0, m_data, m_last and col hold stable.
REQ-022 Simultaneous commit and pop leaves the committed count unchanged.
REQ-022a Simultaneous reservation and pop leaves the reservation count unchanged, and in_rdy reflects the registered counts.
REQ-023 Arithmetic: data is passed bit-exact with no width change, except as stated in REQ-028.

Reset
REQ-024 While rst=1: in_rdy=1, ovf=0, m_vld=0, m_last=0, m_data=0; pointers, col, counts and the skew pipeline are zero, and storage is zeroed.
REQ-025 Reset asserted mid-transfer or with vectors in flight discards all of them; after release no stale beat is emitted.
REQ-026 Deassertion needs no synchronization inside the block, and the first vld_o is accepted in the first cycle after release.

Configuration
REQ-027 Macro ARRAY_DRAIN_RELU_EN selects ReLU at the output.
REQ-028 When ARRAY_DRAIN_RELU_EN is defined, m_data = 0 for any negative stored value and the value unchanged otherwise; storage keeps the raw values.
REQ-029 When ARRAY_DRAIN_RELU_EN is undefined, m_data is the raw signed value and no ReLU logic is synthesized.

Verification (bench parameters WIDTH=4, DEPTH=2)
REQ-030 Single vector: vld_o at cycle 0 with column w driving 10+w at cycle w, m_rdy=1 -> m_vld from cycle 4, beats 10,11,12,13, m_last on the 4th beat, then m_vld=0.
REQ-031 Back-to-back: vld_o in cycles 0 and 1, m_rdy=1 -> 8 contiguous beats in order, m_last on beats 4 and 8, ovf=0.
REQ-032 Overflow: m_rdy=0, vld_o in cycles 0,1,2 -> in_rdy=0 from cycle 2, third vector dropped, ovf=1; release m_rdy -> exactly 8 beats.
REQ-033 Stall: m_rdy toggled 1,0,0,1 during a vector -> m_data held during the zeros, no beat lost or duplicated.
REQ-034 ReLU: column values -5,0,7,-1 -> with ARRAY_DRAIN_RELU_EN 0,0,7,0; without it -5,0,7,-1.
REQ-035 Reset mid-operation: rst pulsed after beat 2 of 4 -> outputs at reset values immediately; a new vector afterwards drains cleanly starting at column 0.

Source files
------------

// File: rtl/array_drain.sv
// array_drain -- collects skewed column results from a systolic array into a
// small vector buffer and serializes them, one column per beat, onto a
// valid/ready stream.
//
// A vld_o pulse reserves one buffer slot. Column w of that vector arrives w
// cycles after the pulse. A skew pipeline carries the slot index beside the
// valid bit so that each column lands in the slot reserved for it. Once the
// last column is written the vector is committed and becomes visible to the
// output side.
//
// Parameters
//   WIDTH  : number of array columns (>= 2)
//   OWIDTH : signed result width per column
//   DEPTH  : vector buffer entries (power of two, >= 2)
//
// Ports
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset
//   ofm     : column results, signed OWIDTH each, WIDTH columns
//   vld_o   : column 0 valid this cycle; column w valid w cycles later
//   in_rdy  : a slot can be reserved, so a vld_o pulse this cycle is taken
//   ovf     : sticky, a vld_o pulse was dropped; cleared only by reset
//   m_data  : serialized column result
//   m_vld   : m_data valid
//   m_rdy   : downstream accepts the beat
//   m_last  : beat carries column WIDTH-1
//
// Configuration macro
//   ARRAY_DRAIN_RELU_EN : when defined, negative values are output as zero.
//                         Storage always keeps the raw values.
module array_drain #(
  parameter int WIDTH  = 14,
  parameter int OWIDTH = 24,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [OWIDTH-1:0] ofm [WIDTH-1:0],
  input  logic                     vld_o,
  output logic                     in_rdy,
  output logic                     ovf,
  output logic signed [OWIDTH-1:0] m_data,
  output logic                     m_vld,
  input  logic                     m_rdy,
  output logic                     m_last
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int NW = $clog2(DEPTH + 1);

  // Output transform: ReLU when enabled, pass-through otherwise.
  function automatic logic signed [OWIDTH-1:0] out_xform(
    input logic signed [OWIDTH-1:0] v
  );
`ifdef ARRAY_DRAIN_RELU_EN
    if (v[OWIDTH-1]) begin
      out_xform = {OWIDTH{1'b0}};
    end else begin
      out_xform = v;
    end
`else
    out_xform = v;
`endif
  endfunction

  logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]            col_q, col_d;
  // res_cnt counts every occupied slot (in flight plus committed);
  // com_cnt counts only the committed ones.
  logic [NW-1:0]            res_cnt_q, res_cnt_d;
  logic [NW-1:0]            com_cnt_q, com_cnt_d;
  logic                     ovf_q, ovf_d;
  // Stage k holds the reservation made k cycles ago. Stage 0 is the live
  // acceptance itself, so only stages 1..WIDTH-1 need flops.
  logic [WIDTH-1:1]         sk_vld_q, sk_vld_d;
  logic [PW-1:0]            sk_slot_q [1:WIDTH-1];
  logic [PW-1:0]            sk_slot_d [1:WIDTH-1];
  logic signed [OWIDTH-1:0] mem_q [DEPTH-1:0][WIDTH-1:0];
  logic signed [OWIDTH-1:0] mem_d [DEPTH-1:0][WIDTH-1:0];

  logic                     acc_s;
  logic                     commit_s;
  logic                     pop_s;
  logic                     beat_s;
  logic                     at_last_s;

  // Output decode. Every output depends on registered state only.
  always_comb begin
    in_rdy    = (res_cnt_q < NW'(DEPTH));
    m_vld     = (com_cnt_q != {NW{1'b0}});
    at_last_s = (col_q == CW'(WIDTH - 1));
    m_last    = m_vld & at_last_s;
    ovf       = ovf_q;
    if (m_vld) begin
      m_data = out_xform(mem_q[rd_ptr_q][col_q]);
    end else begin
      m_data = {OWIDTH{1'b0}};
    end
  end

  // Next-state logic: reservation, skew pipeline, capture, commit and pop.
  always_comb begin
    acc_s    = vld_o & in_rdy;
    commit_s = sk_vld_q[WIDTH-1];
    beat_s   = m_vld & m_rdy;
    pop_s    = beat_s & at_last_s;

    wr_ptr_d  = acc_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d  = pop_s ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
    res_cnt_d = res_cnt_q + NW'(acc_s) - NW'(pop_s);
    com_cnt_d = com_cnt_q + NW'(commit_s) - NW'(pop_s);
    ovf_d     = ovf_q | (vld_o & ~in_rdy);

    if (pop_s) begin
      col_d = {CW{1'b0}};
    end else if (beat_s) begin
      col_d = col_q + CW'(1);
    end else begin
      col_d = col_q;
    end

    sk_vld_d[1]  = acc_s;
    sk_slot_d[1] = wr_ptr_q;
    for (int k = 2; k < WIDTH; k++) begin
      sk_vld_d[k]  = sk_vld_q[k-1];
      sk_slot_d[k] = sk_slot_q[k-1];
    end

    // Column 0 goes straight into the freshly reserved slot. Column w uses
    // the slot carried w stages down the skew pipeline.
    mem_d = mem_q;
    if (acc_s) begin
      mem_d[wr_ptr_q][0] = ofm[0];
    end else begin
      mem_d[wr_ptr_q][0] = mem_q[wr_ptr_q][0];
    end
    for (int w = 1; w < WIDTH; w++) begin
      if (sk_vld_q[w]) begin
        mem_d[sk_slot_q[w]][w] = ofm[w];
      end else begin
        mem_d[sk_slot_q[w]][w] = mem_q[sk_slot_q[w]][w];
      end
    end
  end

  // State registers; reset clears everything, including storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= {PW{1'b0}};
      rd_ptr_q  <= {PW{1'b0}};
      col_q     <= {CW{1'b0}};
      res_cnt_q <= {NW{1'b0}};
      com_cnt_q <= {NW{1'b0}};
      ovf_q     <= 1'b0;
      sk_vld_q  <= {(WIDTH-1){1'b0}};
      for (int k = 1; k < WIDTH; k++) begin
        sk_slot_q[k] <= {PW{1'b0}};
      end
      for (int d = 0; d < DEPTH; d++) begin
        for (int w = 0; w < WIDTH; w++) begin
          mem_q[d][w] <= {OWIDTH{1'b0}};
        end
      end
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      col_q     <= col_d;
      res_cnt_q <= res_cnt_d;
      com_cnt_q <= com_cnt_d;
      ovf_q     <= ovf_d;
      sk_vld_q  <= sk_vld_d;
      sk_slot_q <= sk_slot_d;
      mem_q     <= mem_d;
    end
  end

endmodule
